uart_rx_ctrl: RTL and testbench
===============================

Name: uart_rx_ctrl

Overview:
- Frame-level sequencer for the UART receiver, on the RX clock, which runs at PRESCALE × baud.
- Detects the start bit and owns the oversampling edge counter and bit counter.
- Drives one-cycle enable pulses to the data-sampling, deserializer, start-check, parity-check and stop-check blocks.
- Captures their error results and issues data_valid for each clean frame.

Parameters:
- PRESC_W, 6: width of the prescale input and the edge counter.
- DATA_W, 8: data bits per frame.

Ports:
- clk  in  1  RX clock; one clock domain.
- rst  in  1  asynchronous active-low reset.
- rx_in  in  1  serial line, already synchronised; idles high.
- prescale  in  PRESC_W  oversampling ratio. Legal values 8, 16, 32; any other value is treated as 8.
- par_en  in  1  a parity bit is present when 1.
- strt_glitch  in  1  result from the start-check block.
- par_err  in  1  result from the parity-check block. Valid only the cycle after par_chk_en; it self-clears when par_chk_en is low.
- stp_err  in  1  result from the stop-check block.
- edge_cnt  out  PRESC_W  current oversample index, 0..prescale-1.
- bit_cnt  out  4  frame bit index: start=0, data=1..DATA_W, parity=DATA_W+1, stop=last.
- dat_samp_en  out  1  high in every state except IDLE.
- deser_en  out  1  one-cycle pulse per data bit.
- strt_chk_en, par_chk_en, stp_chk_en  out  1 each  one-cycle check pulses.
- data_valid  out  1  one-cycle pulse per clean frame.

Behaviour:
- Reset: every output is 0, state is IDLE, and the captured error flags are cleared. Reset asserted mid-frame aborts the frame immediately; no data_valid is issued.
- States: IDLE, START, DATA, PARITY, STOP.
- Definitions: H = prescale/2. CHK = H+2, the cycle majority sampling is complete. CAP = H+3, the cycle checker results are captured.
- edge_cnt: increments every cycle outside IDLE and wraps prescale-1 → 0. bit_cnt increments on each wrap.
- IDLE: edge_cnt=0, bit_cnt=0. On rx_in=0 go to START; edge_cnt is 0 in the first START cycle.
- START:
  - strt_chk_en pulses at edge_cnt=CHK.
  - strt_glitch is captured at CAP. If it is 1, go to IDLE the next cycle.
  - Otherwise go to DATA at the wrap.
- DATA:
  - deser_en pulses at CHK for each bit.
  - After DATA_W bits (wrap with bit_cnt=DATA_W), go to PARITY if par_en, else STOP.
- PARITY:
  - par_chk_en pulses at CHK for exactly one cycle.
  - par_err is captured into a sticky flag at CAP. Go to STOP at the wrap.
- STOP:
  - stp_chk_en pulses at CHK; stp_err is captured at CAP.
  - At edge_cnt=prescale-1, data_valid pulses for one cycle, but only if the sticky parity and stop flags are both 0.
  - Next state is START if rx_in=0 (back-to-back frame), else IDLE. edge_cnt and bit_cnt restart at 0. Sticky flags clear on leaving STOP.
- par_en and prescale are sampled only in IDLE. Changes mid-frame take effect on the next frame.
- Enable pulses never overlap; at most one is high in any cycle.

Optional Feature:
- Macro: UART_RX_ERR_STATUS_EN.
- When defined:
  - Adds outputs par_err_o and stp_err_o.
  - Each pulses for one cycle, in the same cycle data_valid would have fired, when the corresponding sticky flag is set.
  - Adds frame_abort, which pulses when a start glitch returns the FSM to IDLE.
- When not defined: none of these ports exist, and errors silently suppress data_valid.

Decomposition:
- Shared package uart_rx_pkg holds:
  - the state encoding enum (IDLE/START/DATA/PARITY/STOP);
  - the legal prescale constants 8/16/32;
  - the CHK/CAP offset constants.
- One sub-module: uart_rx_edge_bit_cnt, holding the edge and bit counters with their wrap and clear logic. The FSM and pulse generation remain in uart_rx_ctrl.

Test Plan:
- prescale=8, par_en=1, frame 0xA5 with correct parity: exactly 8 deser_en pulses; par_chk_en pulses once at edge_cnt=6 of bit 9; data_valid at edge_cnt=7 of bit 10; no other pulses.
- prescale=16, par_en=0, back-to-back 0x3C then 0xC3 with no idle gap: two data_valid pulses 160 cycles apart; the FSM goes STOP→START directly.
- Parity error: par_err=1 in the cycle after par_chk_en → no data_valid. With UART_RX_ERR_STATUS_EN, par_err_o pulses once.
- Start glitch: rx_in low for 3 cycles at prescale=8, with strt_glitch=1 at CAP → return to IDLE; no deser_en; frame_abort pulses if enabled.
- Stop error: stp_err=1 at CAP, prescale=32 → no data_valid; next frame with rx_in=1 between frames is received normally.
- Reset mid-DATA (rst low at bit 4): all outputs 0 while rst is low; after release, IDLE; the next frame decodes correctly.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared definitions for the UART receive frame sequencer.
// Holds the FSM state encoding, the legal oversampling ratios and the
// check/capture offsets measured from the middle of each bit.
package uart_rx_pkg;

  // Frame sequencer states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  // Oversampling ratios the receiver understands
  localparam int unsigned PRESC_8  = 8;
  localparam int unsigned PRESC_16 = 16;
  localparam int unsigned PRESC_32 = 32;

  // Majority sampling finishes two oversamples after mid-bit, and the
  // checker blocks answer one cycle after that.
  localparam int unsigned CHK_OFS = 2;
  localparam int unsigned CAP_OFS = 3;

  // Any ratio other than 16 or 32 falls back to 8
  function automatic int unsigned legal_prescale(input int unsigned p);
    if ((p == PRESC_16) || (p == PRESC_32)) begin
      return p;
    end
    return PRESC_8;
  endfunction

endpackage

// File: rtl/uart_rx_edge_bit_cnt.sv
// Oversample edge counter and frame bit counter for the UART receiver.
// The edge counter runs 0..prescale-1 and wraps; each wrap advances the
// bit counter. A clear request returns both to zero and wins over counting.
module uart_rx_edge_bit_cnt
  import uart_rx_pkg::*;
#(
  parameter int PRESC_W = 6
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_run,
  input  logic               i_clear,
  input  logic [PRESC_W-1:0] i_prescale,
  output logic [PRESC_W-1:0] o_edge_cnt,
  output logic [3:0]         o_bit_cnt,
  output logic               o_wrap
);

  logic [PRESC_W-1:0] r_edge_cnt;
  logic [3:0]         r_bit_cnt;
  logic               w_wrap;

  assign w_wrap     = (r_edge_cnt == (i_prescale - PRESC_W'(1)));
  assign o_wrap     = w_wrap;
  assign o_edge_cnt = r_edge_cnt;
  assign o_bit_cnt  = r_bit_cnt;

  // Advance the oversample index, rolling into the next bit on wrap
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
    end else if (i_clear) begin
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
    end else if (i_run) begin
      if (w_wrap) begin
        r_edge_cnt <= '0;
        r_bit_cnt  <= r_bit_cnt + 4'd1;
      end else begin
        r_edge_cnt <= r_edge_cnt + PRESC_W'(1);
      end
    end
  end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive frame sequencer. Detects the start bit, walks the frame
// through START/DATA/PARITY/STOP, strobes the sampling and checker blocks
// once per bit and raises data_valid for frames without errors.
// Optional error status outputs are built when UART_RX_ERR_STATUS_EN is defined.
module uart_rx_ctrl
  import uart_rx_pkg::*;
#(
  parameter int PRESC_W = 6,
  parameter int DATA_W  = 8
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_rx_in,
  input  logic [PRESC_W-1:0] i_prescale,
  input  logic               i_par_en,
  input  logic               i_strt_glitch,
  input  logic               i_par_err,
  input  logic               i_stp_err,
  output logic [PRESC_W-1:0] o_edge_cnt,
  output logic [3:0]         o_bit_cnt,
  output logic               o_dat_samp_en,
  output logic               o_deser_en,
  output logic               o_strt_chk_en,
  output logic               o_par_chk_en,
  output logic               o_stp_chk_en,
`ifdef UART_RX_ERR_STATUS_EN
  output logic               o_par_err,
  output logic               o_stp_err,
  output logic               o_frame_abort,
`endif
  output logic               o_data_valid
);

  rx_state_e          r_state;
  rx_state_e          w_next_state;

  logic [PRESC_W-1:0] r_prescale;
  logic               r_par_en;
  logic               r_par_flag;
  logic               r_stp_flag;

  logic [PRESC_W-1:0] w_edge_cnt;
  logic [3:0]         w_bit_cnt;
  logic               w_wrap;
  logic [PRESC_W-1:0] w_chk;
  logic [PRESC_W-1:0] w_cap;
  logic               w_chk_hit;
  logic               w_cap_hit;
  logic               w_cnt_run;
  logic               w_cnt_clear;
  logic               w_frame_end;
  logic               w_par_hit;
  logic               w_stp_hit;
  logic               w_stp_any;

  // Check and capture points sit just after the middle of each bit
  assign w_chk     = (r_prescale >> 1) + PRESC_W'(CHK_OFS);
  assign w_cap     = (r_prescale >> 1) + PRESC_W'(CAP_OFS);
  assign w_chk_hit = (w_edge_cnt == w_chk);
  assign w_cap_hit = (w_edge_cnt == w_cap);

  // Counters run through the frame and restart whenever the frame ends,
  // including a direct STOP to START hand-over.
  assign w_frame_end = (r_state == ST_STOP) && w_wrap;
  assign w_cnt_run   = (r_state != ST_IDLE);
  assign w_cnt_clear = (w_next_state == ST_IDLE) || w_frame_end;

  assign w_par_hit = (r_state == ST_PARITY) && w_cap_hit && i_par_err;
  assign w_stp_hit = (r_state == ST_STOP) && w_cap_hit && i_stp_err;
  // At prescale 8 the stop capture lands on the last cycle, so the verdict
  // must see the flag being captured this cycle as well as the stored one.
  assign w_stp_any = r_stp_flag || w_stp_hit;

  uart_rx_edge_bit_cnt #(
    .PRESC_W (PRESC_W)
  ) u_edge_bit_cnt (
    .i_clk      (i_clk),
    .i_rst_n    (i_rst_n),
    .i_run      (w_cnt_run),
    .i_clear    (w_cnt_clear),
    .i_prescale (r_prescale),
    .o_edge_cnt (w_edge_cnt),
    .o_bit_cnt  (w_bit_cnt),
    .o_wrap     (w_wrap)
  );

  // Frame settings follow the inputs only while idle, so a frame in flight
  // keeps the ratio and parity mode it started with.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prescale <= PRESC_W'(PRESC_8);
      r_par_en   <= 1'b0;
    end else if (r_state == ST_IDLE) begin
      r_prescale <= PRESC_W'(legal_prescale(32'(i_prescale)));
      r_par_en   <= i_par_en;
    end
  end

  // Sticky parity and stop error flags, dropped when the frame ends
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_par_flag <= 1'b0;
      r_stp_flag <= 1'b0;
    end else if (w_frame_end || (w_next_state == ST_IDLE)) begin
      r_par_flag <= 1'b0;
      r_stp_flag <= 1'b0;
    end else begin
      if (w_par_hit) begin
        r_par_flag <= 1'b1;
      end
      if (w_stp_hit) begin
        r_stp_flag <= 1'b1;
      end
    end
  end

  // State register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state decision; a start glitch takes priority over the bit wrap
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE: begin
        if (!i_rx_in) begin
          w_next_state = ST_START;
        end
      end
      ST_START: begin
        if (w_cap_hit && i_strt_glitch) begin
          w_next_state = ST_IDLE;
        end else if (w_wrap) begin
          w_next_state = ST_DATA;
        end
      end
      ST_DATA: begin
        if (w_wrap && (w_bit_cnt == 4'(DATA_W))) begin
          w_next_state = r_par_en ? ST_PARITY : ST_STOP;
        end
      end
      ST_PARITY: begin
        if (w_wrap) begin
          w_next_state = ST_STOP;
        end
      end
      ST_STOP: begin
        if (w_wrap) begin
          w_next_state = i_rx_in ? ST_IDLE : ST_START;
        end
      end
      default: begin
        w_next_state = ST_IDLE;
      end
    endcase
  end

  // Enable pulses; each belongs to one state so they can never overlap
  always_comb begin
    o_dat_samp_en = (r_state != ST_IDLE);
    o_strt_chk_en = 1'b0;
    o_deser_en    = 1'b0;
    o_par_chk_en  = 1'b0;
    o_stp_chk_en  = 1'b0;
    o_data_valid  = 1'b0;
    case (r_state)
      ST_START:  o_strt_chk_en = w_chk_hit;
      ST_DATA:   o_deser_en    = w_chk_hit;
      ST_PARITY: o_par_chk_en  = w_chk_hit;
      ST_STOP: begin
        o_stp_chk_en = w_chk_hit;
        o_data_valid = w_wrap && !r_par_flag && !w_stp_any;
      end
      default: begin
        o_dat_samp_en = 1'b0;
      end
    endcase
  end

`ifdef UART_RX_ERR_STATUS_EN
  // Error status pulses share the cycle where data_valid would have fired
  always_comb begin
    o_par_err     = w_frame_end && r_par_flag;
    o_stp_err     = w_frame_end && w_stp_any;
    o_frame_abort = (r_state == ST_START) && w_cap_hit && i_strt_glitch;
  end
`endif

  assign o_edge_cnt = w_edge_cnt;
  assign o_bit_cnt  = w_bit_cnt;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed testbench for uart_rx_ctrl. Drives serial frames, models the
// external checker blocks answering one cycle after their enable pulse,
// and counts the sequencer's pulses on the falling clock edge.
`timescale 1ns/1ps
module tb_uart_rx_ctrl;

  logic       clk = 1'b0;
  logic       rstN = 1'b0;
  logic       rxIn = 1'b1;
  logic [5:0] prescale = 6'd8;
  logic       parEn = 1'b0;
  logic       strtGlitch = 1'b0;
  logic       parErr = 1'b0;
  logic       stpErr = 1'b0;

  logic [5:0] edgeCnt;
  logic [3:0] bitCnt;
  logic       datSampEn, deserEn, strtChkEn, parChkEn, stpChkEn, dataValid;
`ifdef UART_RX_ERR_STATUS_EN
  logic       parErrO, stpErrO, frameAbort;
`endif

  int compareCount = 0;
  int mismatchCount = 0;

  // pulse counters, written only by the monitor
  int cyc = 0;
  int nDeser = 0, nStrt = 0, nPar = 0, nStp = 0, nValid = 0, nOverlap = 0, nSampLow = 0;
  int nParErrO = 0, nStpErrO = 0, nAbort = 0;
  int parEdge = -1, parBit = -1, dvEdge = -1, dvBit = -1;
  int lastDvCyc = 0, prevDvCyc = 0, lastDvLow = 0, prevDvLow = 0;
  bit strtSeen = 0, parSeen = 0, stpSeen = 0;

  // error injection requests for the checker-block model
  bit injGlitch = 0, injPar = 0, injStp = 0;

  // snapshots
  int sDeser, sStrt, sPar, sStp, sValid, sParErrO, sStpErrO, sAbort;

  always #5 clk = ~clk;

  uart_rx_ctrl #(.PRESC_W(6), .DATA_W(8)) dut (
    .i_clk         (clk),
    .i_rst_n       (rstN),
    .i_rx_in       (rxIn),
    .i_prescale    (prescale),
    .i_par_en      (parEn),
    .i_strt_glitch (strtGlitch),
    .i_par_err     (parErr),
    .i_stp_err     (stpErr),
    .o_edge_cnt    (edgeCnt),
    .o_bit_cnt     (bitCnt),
    .o_dat_samp_en (datSampEn),
    .o_deser_en    (deserEn),
    .o_strt_chk_en (strtChkEn),
    .o_par_chk_en  (parChkEn),
    .o_stp_chk_en  (stpChkEn),
`ifdef UART_RX_ERR_STATUS_EN
    .o_par_err     (parErrO),
    .o_stp_err     (stpErrO),
    .o_frame_abort (frameAbort),
`endif
    .o_data_valid  (dataValid)
  );

  // Monitor: tally every pulse once per cycle, away from the active edge
  always @(negedge clk) begin
    cyc++;
    if (deserEn) nDeser++;
    if (strtChkEn) nStrt++;
    if (stpChkEn) nStp++;
    if (parChkEn) begin
      nPar++;
      parEdge = int'(edgeCnt);
      parBit  = int'(bitCnt);
    end
    if (dataValid) begin
      nValid++;
      dvEdge    = int'(edgeCnt);
      dvBit     = int'(bitCnt);
      prevDvCyc = lastDvCyc;
      lastDvCyc = cyc;
      prevDvLow = lastDvLow;
      lastDvLow = nSampLow;
    end
    if ((int'(deserEn) + int'(strtChkEn) + int'(parChkEn) + int'(stpChkEn)) > 1) nOverlap++;
    if (!datSampEn) nSampLow++;
`ifdef UART_RX_ERR_STATUS_EN
    if (parErrO) nParErrO++;
    if (stpErrO) nStpErrO++;
    if (frameAbort) nAbort++;
`endif
    strtSeen = strtChkEn;
    parSeen  = parChkEn;
    stpSeen  = stpChkEn;
  end

  // Checker-block model: answer in the cycle after each check enable
  always @(posedge clk) begin
    #1;
    strtGlitch = strtSeen && injGlitch;
    parErr     = parSeen && injPar;
    stpErr     = stpSeen && injStp;
  end

  task automatic checkOutput(input string tag, input int observed, input int expected);
    compareCount++;
    if (observed !== expected) begin
      mismatchCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic driveBit(input logic b, input int p);
    rxIn = b;
    waitCycles(p);
  endtask

  // One complete frame on the line: start, data LSB first, optional even parity, stop
  task automatic applyStimulus(input logic [7:0] data, input bit withPar, input int p);
    driveBit(1'b0, p);
    for (int i = 0; i < 8; i++) driveBit(data[i], p);
    if (withPar) driveBit(^data, p);
    driveBit(1'b1, p);
  endtask

  task automatic takeSnapshot();
    sDeser = nDeser; sStrt = nStrt; sPar = nPar; sStp = nStp; sValid = nValid;
    sParErrO = nParErrO; sStpErrO = nStpErrO; sAbort = nAbort;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_edge"}, int'(edgeCnt), 0);
    checkOutput({tag, "_bit"}, int'(bitCnt), 0);
    checkOutput({tag, "_pulses"},
                int'({datSampEn, deserEn, strtChkEn, parChkEn, stpChkEn, dataValid}), 0);
  endtask

  initial begin
    $display("[TB] uart_rx_ctrl directed test start");

    // Reset state
    repeat (2) @(negedge clk);
    checkAllZero("reset");
    @(posedge clk); #1;
    rstN = 1'b1;
    waitCycles(3);

    // prescale 8 with parity, frame 0xA5
    prescale = 6'd8; parEn = 1'b1;
    waitCycles(2);
    takeSnapshot();
    applyStimulus(8'hA5, 1'b1, 8);
    waitCycles(4);
    checkOutput("p8_deser", nDeser - sDeser, 8);
    checkOutput("p8_strtchk", nStrt - sStrt, 1);
    checkOutput("p8_parchk", nPar - sPar, 1);
    checkOutput("p8_stpchk", nStp - sStp, 1);
    checkOutput("p8_valid", nValid - sValid, 1);
    checkOutput("p8_par_edge", parEdge, 6);
    checkOutput("p8_par_bit", parBit, 9);
    checkOutput("p8_dv_edge", dvEdge, 7);
    checkOutput("p8_dv_bit", dvBit, 10);
    checkOutput("p8_idle", int'(datSampEn), 0);

    // prescale 16 without parity, back-to-back 0x3C then 0xC3
    prescale = 6'd16; parEn = 1'b0;
    waitCycles(2);
    takeSnapshot();
    applyStimulus(8'h3C, 1'b0, 16);
    applyStimulus(8'hC3, 1'b0, 16);
    waitCycles(4);
    checkOutput("b2b_valid", nValid - sValid, 2);
    checkOutput("b2b_deser", nDeser - sDeser, 16);
    checkOutput("b2b_spacing", lastDvCyc - prevDvCyc, 160);
    checkOutput("b2b_no_idle", lastDvLow - prevDvLow, 0);
    checkOutput("b2b_dv_edge", dvEdge, 15);
    checkOutput("b2b_dv_bit", dvBit, 9);

    // parity error suppresses data_valid
    prescale = 6'd8; parEn = 1'b1; injPar = 1'b1;
    waitCycles(2);
    takeSnapshot();
    applyStimulus(8'h5A, 1'b1, 8);
    waitCycles(4);
    injPar = 1'b0;
    checkOutput("parerr_parchk", nPar - sPar, 1);
    checkOutput("parerr_valid", nValid - sValid, 0);
`ifdef UART_RX_ERR_STATUS_EN
    checkOutput("parerr_status", nParErrO - sParErrO, 1);
    checkOutput("parerr_stp_status", nStpErrO - sStpErrO, 0);
`endif

    // start glitch: line low for 3 cycles, start check reports a glitch
    parEn = 1'b0; injGlitch = 1'b1;
    waitCycles(2);
    takeSnapshot();
    driveBit(1'b0, 3);
    driveBit(1'b1, 12);
    injGlitch = 1'b0;
    checkOutput("glitch_strtchk", nStrt - sStrt, 1);
    checkOutput("glitch_deser", nDeser - sDeser, 0);
    checkOutput("glitch_valid", nValid - sValid, 0);
    checkOutput("glitch_idle", int'(datSampEn), 0);
    checkOutput("glitch_edge", int'(edgeCnt), 0);
`ifdef UART_RX_ERR_STATUS_EN
    checkOutput("glitch_abort", nAbort - sAbort, 1);
`endif

    // stop error at prescale 32, then a clean frame after an idle gap
    prescale = 6'd32; injStp = 1'b1;
    waitCycles(2);
    takeSnapshot();
    applyStimulus(8'h96, 1'b0, 32);
    waitCycles(4);
    injStp = 1'b0;
    checkOutput("stperr_stpchk", nStp - sStp, 1);
    checkOutput("stperr_valid", nValid - sValid, 0);
`ifdef UART_RX_ERR_STATUS_EN
    checkOutput("stperr_status", nStpErrO - sStpErrO, 1);
`endif
    waitCycles(5);
    takeSnapshot();
    applyStimulus(8'h5A, 1'b0, 32);
    waitCycles(4);
    checkOutput("p32_valid", nValid - sValid, 1);
    checkOutput("p32_deser", nDeser - sDeser, 8);
    checkOutput("p32_dv_edge", dvEdge, 31);

    // reset during data bit 4 aborts the frame
    prescale = 6'd8; parEn = 1'b0;
    waitCycles(2);
    takeSnapshot();
    driveBit(1'b0, 8);
    driveBit(1'b1, 8);
    driveBit(1'b1, 8);
    driveBit(1'b1, 8);
    rxIn = 1'b1;
    waitCycles(4);
    checkOutput("rst_mid_bit", int'(bitCnt), 4);
    rstN = 1'b0;
    @(negedge clk);
    checkAllZero("rst_held");
    waitCycles(3);
    checkAllZero("rst_held_late");
    rstN = 1'b1;
    waitCycles(3);
    checkOutput("rst_idle", int'(datSampEn), 0);
    checkOutput("rst_no_valid", nValid - sValid, 0);
    takeSnapshot();
    applyStimulus(8'h81, 1'b0, 8);
    waitCycles(4);
    checkOutput("rst_next_valid", nValid - sValid, 1);
    checkOutput("rst_next_deser", nDeser - sDeser, 8);

    // illegal prescale behaves as 8
    prescale = 6'd12;
    waitCycles(2);
    takeSnapshot();
    applyStimulus(8'h33, 1'b0, 8);
    waitCycles(4);
    checkOutput("p12_valid", nValid - sValid, 1);
    checkOutput("p12_dv_edge", dvEdge, 7);
    checkOutput("p12_dv_bit", dvBit, 9);

    checkOutput("no_overlap", nOverlap, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, mismatchCount);
    $finish;
  end

endmodule
